// File: rtl/dft_result_sink_pkg.sv
// Shared types for the DFT result path: float32 split into fields, complex
// pair, output-register state encoding and a special-exponent helper.
package dft_pkg;

    localparam logic [7:0] FP_EXP_SPECIAL = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float32_t;

    typedef struct packed {
        float32_t re;
        float32_t im;
    } cplx_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Inf and NaN both carry the all-ones exponent.
    function automatic logic is_special(input float32_t f);
        return (f.exp == FP_EXP_SPECIAL);
    endfunction

endpackage

// File: rtl/dft_result_sink_if.sv
// One busy/vld float32 stream. The producer drives vld/data, the consumer
// drives busy; a word moves on a rising edge with vld=1 and busy=0.
interface dft_result_sink_if;
    import dft_pkg::*;

    logic     vld;
    logic     busy;
    float32_t data;

    modport master (output vld, output data, input busy);
    modport slave  (input vld, input data, output busy);

endinterface

// File: rtl/dft_result_sink_lane_buf.sv
// dft_lane_buf: 2-entry busy/vld buffer for one float32 lane.
// busy is a register equal to (count==2) so it never depends on vld.
// Push and pop may coincide; order is kept by separate read/write pointers.
module dft_lane_buf
    import dft_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    dft_result_sink_if.slave s_lane,
    input  logic             i_pop,
    output logic             o_head_vld,
    output float32_t         o_head
);

    float32_t   mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       busy_q;
    logic       push;

    assign push         = s_lane.vld && !busy_q;
    assign s_lane.busy  = busy_q;
    assign o_head_vld   = (count_q != 2'd0);
    assign o_head       = mem_q[rd_ptr_q];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({push, i_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers, occupancy and the registered busy flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            busy_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_lane.data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (i_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            busy_q  <= (count_d == 2'd2);
        end
    end

endmodule

// File: rtl/dft_result_sink.sv
// dft_result_sink: pairs the real and imag DFT result lanes bin by bin and
// emits one complex word per bin on a busy/vld stream with bin index,
// last flag and a frame-done pulse.
// Optional per-frame special-value counter: define DFT_SINK_STATS_EN.
//
// Output register FSM:
//   state     | meaning
//   OUT_EMPTY | no word held, o_cplx_vld=0
//   OUT_FULL  | word held, o_cplx_vld=1, fields stable until transfer
module dft_result_sink
    import dft_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int BIN_W    = $clog2(N_POINTS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dft_real_vld,
    input  logic [22:0]      i_dft_real_data_man,
    input  logic [7:0]       i_dft_real_data_exp,
    input  logic             i_dft_real_data_sign,
    output logic             o_dft_real_busy,
    input  logic             i_dft_imag_vld,
    input  logic [22:0]      i_dft_imag_data_man,
    input  logic [7:0]       i_dft_imag_data_exp,
    input  logic             i_dft_imag_data_sign,
    output logic             o_dft_imag_busy,
    output logic             o_cplx_vld,
    input  logic             i_cplx_busy,
    output logic [22:0]      o_cplx_re_man,
    output logic [7:0]       o_cplx_re_exp,
    output logic             o_cplx_re_sign,
    output logic [22:0]      o_cplx_im_man,
    output logic [7:0]       o_cplx_im_exp,
    output logic             o_cplx_im_sign,
    output logic [BIN_W-1:0] o_cplx_bin,
    output logic             o_cplx_last,
    output logic             o_frame_done
`ifdef DFT_SINK_STATS_EN
    ,
    output logic [7:0]       o_special_cnt
`endif
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_POINTS - 1);

    dft_result_sink_if real_if ();
    dft_result_sink_if imag_if ();

    assign real_if.vld     = i_dft_real_vld;
    assign real_if.data    = {i_dft_real_data_sign, i_dft_real_data_exp, i_dft_real_data_man};
    assign o_dft_real_busy = real_if.busy;
    assign imag_if.vld     = i_dft_imag_vld;
    assign imag_if.data    = {i_dft_imag_data_sign, i_dft_imag_data_exp, i_dft_imag_data_man};
    assign o_dft_imag_busy = imag_if.busy;

    float32_t         re_head;
    float32_t         im_head;
    logic             re_head_vld;
    logic             im_head_vld;
    logic             load;
    logic             xfer;
    out_state_t       state_q;
    out_state_t       state_d;
    cplx_t            cplx_q;
    logic [BIN_W-1:0] bin_cnt_q;
    logic [BIN_W-1:0] bin_q;
    logic             last_q;
    logic             frame_done_q;

    // Both lanes pop together on load, so they can never drift apart.
    dft_lane_buf u_real_buf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .s_lane     (real_if),
        .i_pop      (load),
        .o_head_vld (re_head_vld),
        .o_head     (re_head)
    );

    dft_lane_buf u_imag_buf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .s_lane     (imag_if),
        .i_pop      (load),
        .o_head_vld (im_head_vld),
        .o_head     (im_head)
    );

    // Downstream transfer and pair-load conditions.
    always_comb begin
        xfer = (state_q == OUT_FULL) && !i_cplx_busy;
        load = re_head_vld && im_head_vld && ((state_q == OUT_EMPTY) || !i_cplx_busy);
    end

    // Output register state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a reload while draining keeps the register full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (load)          state_d = OUT_FULL;
            OUT_FULL:  if (xfer && !load) state_d = OUT_EMPTY;
            default:                      state_d = OUT_EMPTY;
        endcase
    end

    // Valid follows the register state directly.
    always_comb begin
        o_cplx_vld = (state_q == OUT_FULL);
    end

    // Payload, bin tag and frame-done pulse. The bin counter advances per
    // load: every loaded word transfers exactly once, and counting at load
    // keeps the tag correct when a reload coincides with a transfer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cplx_q       <= '0;
            bin_q        <= '0;
            last_q       <= 1'b0;
            bin_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (load) begin
                cplx_q    <= '{re: re_head, im: im_head};
                bin_q     <= bin_cnt_q;
                last_q    <= (bin_cnt_q == LAST_BIN);
                bin_cnt_q <= (bin_cnt_q == LAST_BIN) ? '0 : bin_cnt_q + 1'b1;
            end
            frame_done_q <= xfer && last_q;
        end
    end

    assign o_cplx_re_man  = cplx_q.re.man;
    assign o_cplx_re_exp  = cplx_q.re.exp;
    assign o_cplx_re_sign = cplx_q.re.sign;
    assign o_cplx_im_man  = cplx_q.im.man;
    assign o_cplx_im_exp  = cplx_q.im.exp;
    assign o_cplx_im_sign = cplx_q.im.sign;
    assign o_cplx_bin     = bin_q;
    assign o_cplx_last    = last_q;
    assign o_frame_done   = frame_done_q;

`ifdef DFT_SINK_STATS_EN
    logic [7:0] special_cnt_q;
    logic [7:0] special_final_q;
    logic       word_special;

    assign word_special = is_special(re_head) || is_special(im_head);

    // Per-frame saturating count. Bin 0 of the next frame may load on the
    // same edge the last word leaves, so the final value is snapshotted there
    // and presented during the frame-done cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            special_cnt_q   <= 8'd0;
            special_final_q <= 8'd0;
        end else begin
            if (load) begin
                if (bin_cnt_q == '0) begin
                    special_cnt_q <= word_special ? 8'd1 : 8'd0;
                end else if (word_special && (special_cnt_q != 8'hFF)) begin
                    special_cnt_q <= special_cnt_q + 8'd1;
                end
            end
            if (xfer && last_q) begin
                special_final_q <= special_cnt_q;
            end
        end
    end

    assign o_special_cnt = frame_done_q ? special_final_q : special_cnt_q;
`endif

endmodule

// File: tb/tb_dft_result_sink.sv
// Directed bench for dft_result_sink (N_POINTS=16): reset state, value
// pass-through, full frame streaming, lane skew, downstream stall and
// mid-frame reset.
`timescale 1ns/1ps
module tb_dft_result_sink;
    import dft_pkg::*;

    localparam int N_POINTS = 16;
    localparam int BIN_W    = 4;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_cplx_busy = 1'b0;
    logic             o_dft_real_busy;
    logic             o_dft_imag_busy;
    logic             o_cplx_vld;
    logic [22:0]      o_cplx_re_man;
    logic [7:0]       o_cplx_re_exp;
    logic             o_cplx_re_sign;
    logic [22:0]      o_cplx_im_man;
    logic [7:0]       o_cplx_im_exp;
    logic             o_cplx_im_sign;
    logic [BIN_W-1:0] o_cplx_bin;
    logic             o_cplx_last;
    logic             o_frame_done;
`ifdef DFT_SINK_STATS_EN
    logic [7:0]       o_special_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    dft_result_sink_if real_if ();
    dft_result_sink_if imag_if ();

    assign real_if.busy = o_dft_real_busy;
    assign imag_if.busy = o_dft_imag_busy;

    always #5 i_clk = ~i_clk;

    dft_result_sink #(.N_POINTS(N_POINTS), .BIN_W(BIN_W)) dut (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_dft_real_vld       (real_if.vld),
        .i_dft_real_data_man  (real_if.data.man),
        .i_dft_real_data_exp  (real_if.data.exp),
        .i_dft_real_data_sign (real_if.data.sign),
        .o_dft_real_busy      (o_dft_real_busy),
        .i_dft_imag_vld       (imag_if.vld),
        .i_dft_imag_data_man  (imag_if.data.man),
        .i_dft_imag_data_exp  (imag_if.data.exp),
        .i_dft_imag_data_sign (imag_if.data.sign),
        .o_dft_imag_busy      (o_dft_imag_busy),
        .o_cplx_vld           (o_cplx_vld),
        .i_cplx_busy          (i_cplx_busy),
        .o_cplx_re_man        (o_cplx_re_man),
        .o_cplx_re_exp        (o_cplx_re_exp),
        .o_cplx_re_sign       (o_cplx_re_sign),
        .o_cplx_im_man        (o_cplx_im_man),
        .o_cplx_im_exp        (o_cplx_im_exp),
        .o_cplx_im_sign       (o_cplx_im_sign),
        .o_cplx_bin           (o_cplx_bin),
        .o_cplx_last          (o_cplx_last),
        .o_frame_done         (o_frame_done)
`ifdef DFT_SINK_STATS_EN
        ,
        .o_special_cnt        (o_special_cnt)
`endif
    );

    // Real-lane word for sequence index k: denormal at 0, Inf/NaN at 2 and 9.
    function automatic float32_t mk_re(input int k);
        float32_t f;
        f.sign = k[0];
        f.exp  = (k == 2 || k == 9) ? 8'hFF : 8'(k * 3);
        f.man  = 23'(k * 32'h0001_2345 + 1);
        return f;
    endfunction

    // Imag-lane word: Inf/NaN at 7 and 9, -0 at 5, denormal at 11.
    function automatic float32_t mk_im(input int k);
        float32_t f;
        f.sign = ~k[0];
        f.exp  = (k == 7 || k == 9) ? 8'hFF : 8'(8'h70 + k);
        f.man  = 23'(k * 32'h0000_0777);
        if (k == 5)  f = 32'h8000_0000;
        if (k == 11) f = 32'h0000_0001;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            $error("compare %s", tag);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Check the visible output word against sequence index w.
    task automatic chk_word(input string tag, input int w);
        chk({tag, "_bin"}, 64'(o_cplx_bin), 64'(w % N_POINTS));
        chk({tag, "_re"}, 64'({o_cplx_re_sign, o_cplx_re_exp, o_cplx_re_man}), 64'(mk_re(w)));
        chk({tag, "_im"}, 64'({o_cplx_im_sign, o_cplx_im_exp, o_cplx_im_man}), 64'(mk_im(w)));
        chk({tag, "_last"}, 64'(o_cplx_last), 64'((w % N_POINTS) == N_POINTS - 1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, 64'(o_cplx_vld), 64'(0));
        chk({tag, "_rbusy"}, 64'(o_dft_real_busy), 64'(0));
        chk({tag, "_ibusy"}, 64'(o_dft_imag_busy), 64'(0));
        chk({tag, "_bin"}, 64'(o_cplx_bin), 64'(0));
        chk({tag, "_last"}, 64'(o_cplx_last), 64'(0));
        chk({tag, "_fd"}, 64'(o_frame_done), 64'(0));
        chk({tag, "_re"}, 64'({o_cplx_re_sign, o_cplx_re_exp, o_cplx_re_man}), 64'(0));
        chk({tag, "_im"}, 64'({o_cplx_im_sign, o_cplx_im_exp, o_cplx_im_man}), 64'(0));
`ifdef DFT_SINK_STATS_EN
        chk({tag, "_spc"}, 64'(o_special_cnt), 64'(0));
`endif
    endtask

    task automatic do_reset();
        real_if.vld = 1'b0;
        imag_if.vld = 1'b0;
        i_cplx_busy = 1'b0;
        #2;
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        step();
    endtask

    // Both lanes valid every cycle, no backpressure; edge j carries word j-1.
    task automatic stream_directed(input int stop_j);
        for (int j = 1; j <= stop_j; j++) begin
            real_if.vld  = (j <= N_POINTS);
            real_if.data = mk_re(j - 1);
            imag_if.vld  = (j <= N_POINTS);
            imag_if.data = mk_im(j - 1);
            step();
            chk("fr_vld", 64'(o_cplx_vld), 64'(j >= 2 && j <= N_POINTS + 1));
            if (j >= 2 && j <= N_POINTS + 1) chk_word("fr", j - 2);
            chk("fr_fd", 64'(o_frame_done), 64'(j == N_POINTS + 2));
            chk("fr_rbusy", 64'(o_dft_real_busy), 64'(0));
`ifdef DFT_SINK_STATS_EN
            if (j == N_POINTS + 2) chk("fr_spc", 64'(o_special_cnt), 64'(3));
`endif
        end
        real_if.vld = 1'b0;
        imag_if.vld = 1'b0;
    endtask

    // Scoreboarded stream with a downstream stall while word stall_w is shown.
    task automatic run_stream(input int n_words, input int stall_w, input int stall_len,
                              input int max_cycles, input int exp_fd_cnt);
        int   kr = 0;
        int   ki = 0;
        int   w = 0;
        int   hold = 0;
        int   fd_cnt = 0;
        logic acc_r, acc_i, xfer, xfer_last;
        for (int c = 0; c < max_cycles && w < n_words; c++) begin
            real_if.vld  = (kr < n_words);
            real_if.data = mk_re(kr);
            imag_if.vld  = (ki < n_words);
            imag_if.data = mk_im(ki);
            i_cplx_busy  = o_cplx_vld && (w == stall_w) && (hold < stall_len);
            if (i_cplx_busy) hold++;
            acc_r     = real_if.vld && !o_dft_real_busy;
            acc_i     = imag_if.vld && !o_dft_imag_busy;
            xfer      = o_cplx_vld && !i_cplx_busy;
            xfer_last = xfer && ((w % N_POINTS) == N_POINTS - 1);
            step();
            if (acc_r) kr++;
            if (acc_i) ki++;
            if (xfer) w++;
            chk("st_fd", 64'(o_frame_done), 64'(xfer_last));
            if (o_frame_done) fd_cnt++;
`ifdef DFT_SINK_STATS_EN
            if (o_frame_done) chk("st_spc_frozen", 64'(o_special_cnt), 64'(3));
`endif
            if (o_cplx_vld && w < n_words) chk_word("st", w);
            if (i_cplx_busy && hold == stall_len) begin
                chk("st_rbusy_full", 64'(o_dft_real_busy), 64'(1));
                chk("st_ibusy_full", 64'(o_dft_imag_busy), 64'(1));
            end
        end
        chk("st_words", 64'(w), 64'(n_words));
        chk("st_hold", 64'(hold), 64'(stall_len));
        chk("st_fd_cnt", 64'(fd_cnt), 64'(exp_fd_cnt));
        real_if.vld = 1'b0;
        imag_if.vld = 1'b0;
        i_cplx_busy = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        real_if.vld  = 1'b0;
        real_if.data = '0;
        imag_if.vld  = 1'b0;
        imag_if.data = '0;

        // Reset state.
        #3;
        chk_all_zero("rst");
        @(negedge i_clk);
        i_rst = 1'b1;
        step();

        // 1.0 / -1.0 pass-through and first-word latency.
        real_if.vld  = 1'b1;
        real_if.data = 32'h3F80_0000;
        imag_if.vld  = 1'b1;
        imag_if.data = 32'hBF80_0000;
        step();
        real_if.vld = 1'b0;
        imag_if.vld = 1'b0;
        chk("val_vld_early", 64'(o_cplx_vld), 64'(0));
        step();
        chk("val_vld", 64'(o_cplx_vld), 64'(1));
        chk("val_re_sign", 64'(o_cplx_re_sign), 64'(0));
        chk("val_re_exp", 64'(o_cplx_re_exp), 64'(8'h7F));
        chk("val_re_man", 64'(o_cplx_re_man), 64'(0));
        chk("val_im_sign", 64'(o_cplx_im_sign), 64'(1));
        chk("val_im_exp", 64'(o_cplx_im_exp), 64'(8'h7F));
        chk("val_im_man", 64'(o_cplx_im_man), 64'(0));
        chk("val_bin", 64'(o_cplx_bin), 64'(0));
        step();
        chk("val_vld_drain", 64'(o_cplx_vld), 64'(0));

        // Full frame, back to back.
        do_reset();
        stream_directed(N_POINTS + 3);

        // Real lane leads by three words.
        do_reset();
        real_if.vld  = 1'b1;
        real_if.data = mk_re(0);
        step();
        chk("sk_rbusy_1", 64'(o_dft_real_busy), 64'(0));
        real_if.data = mk_re(1);
        step();
        chk("sk_rbusy_2", 64'(o_dft_real_busy), 64'(1));
        chk("sk_ibusy_2", 64'(o_dft_imag_busy), 64'(0));
        chk("sk_vld_2", 64'(o_cplx_vld), 64'(0));
        real_if.data = mk_re(2);
        step();
        chk("sk_rbusy_3", 64'(o_dft_real_busy), 64'(1));
        chk("sk_vld_3", 64'(o_cplx_vld), 64'(0));
        imag_if.vld  = 1'b1;
        imag_if.data = mk_im(0);
        step();
        chk("sk_vld_4", 64'(o_cplx_vld), 64'(0));
        imag_if.data = mk_im(1);
        step();
        chk("sk_vld_5", 64'(o_cplx_vld), 64'(1));
        chk_word("sk0", 0);
        chk("sk_rbusy_5", 64'(o_dft_real_busy), 64'(0));
        imag_if.data = mk_im(2);
        step();
        chk_word("sk1", 1);
        real_if.vld = 1'b0;
        imag_if.vld = 1'b0;
        step();
        chk_word("sk2", 2);
        step();
        chk("sk_vld_end", 64'(o_cplx_vld), 64'(0));

        // Downstream stall on bin 4, then into bin 1 of the next frame.
        do_reset();
        run_stream(N_POINTS + 2, 4, 5, 80, 1);
        step();
        step();
`ifdef DFT_SINK_STATS_EN
        chk("st_spc_cleared", 64'(o_special_cnt), 64'(0));
`endif

        // Reset while bin 6 is on the output.
        do_reset();
        stream_directed(8);
        chk("mr_pre_bin", 64'(o_cplx_bin), 64'(6));
        #2;
        i_rst = 1'b0;
        #1;
        chk_all_zero("mr");
        @(negedge i_clk);
        i_rst = 1'b1;
        step();
        real_if.vld  = 1'b1;
        real_if.data = mk_re(3);
        imag_if.vld  = 1'b1;
        imag_if.data = mk_im(3);
        step();
        real_if.vld = 1'b0;
        imag_if.vld = 1'b0;
        chk("mr_vld_early", 64'(o_cplx_vld), 64'(0));
        step();
        chk("mr_vld", 64'(o_cplx_vld), 64'(1));
        chk("mr_bin", 64'(o_cplx_bin), 64'(0));
        chk("mr_re", 64'({o_cplx_re_sign, o_cplx_re_exp, o_cplx_re_man}), 64'(mk_re(3)));
        chk("mr_im", 64'({o_cplx_im_sign, o_cplx_im_exp, o_cplx_im_man}), 64'(mk_im(3)));
        for (int i = 0; i < 20; i++) begin
            step();
            chk("mr_no_fd", 64'(o_frame_done), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
